serv_alu_digit: RTL and testbench
=================================

# serv_alu_digit

Parametrised successor to the bit-serial SERV ALU. It processes W bits per cycle instead of one and sequences itself with an internal digit counter and a start/done handshake. It implements add/sub, boolean ops, equality and signed/unsigned less-than over an XLEN-bit operand streamed LSB-digit first. It sits between the register-file read port and the rd write path, in place of the 1-bit ALU, when a wider datapath is configured.

## Interface
- XLEN, 32, operand width in bits.
- W, 1, digit width in bits; legal values 1, 2, 4, 8, 16, 32; must divide XLEN. N = XLEN/W digits per operation.

- clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_start  in  1  start request; accepted only when o_busy=0.
- o_busy  out  1  high while digits 1..N-1 are processed.
- o_done  out  1  one-cycle pulse, cycle after the last digit.
- i_op_b_rs2  in  1  operand B select: 1=i_rs2, 0=i_imm.
- i_sub  in  1  1=subtract (B inverted, carry-in 1); must be 1 for compares.
- i_bool_op  in  2  00 xor, 01 xnor, 10 or, 11 and.
- i_cmp_eq  in  1  o_cmp source: 1=equality, 0=less-than.
- i_cmp_sig  in  1  1=signed less-than, 0=unsigned.
- i_rd_sel  in  3  one-hot: [0] sum, [1] stored lt flag, [2] boolean.
- i_rs1, i_rs2, i_imm  in  W  current operand digits.
- o_rd  out  W  result digit, combinational.
- o_rd_valid  out  1  (i_start & ~o_busy) | o_busy.
- o_cmp  out  1  registered compare result of the last completed operation.

## Operation
- States: IDLE (o_busy=0) and RUN (o_busy=1). Counter cnt, width ceil(log2 N), holds the index of the digit being processed.
- Start cycle: i_start=1 in IDLE processes digit 0 with live control inputs. The controls are latched on the same edge and used for digits 1..N-1. Inputs on later cycles are ignored. If N>1, go to RUN with cnt=1. If N=1, stay IDLE and pulse o_done next cycle.
- RUN: process digit cnt each cycle. Leave RUN after digit N-1, cnt back to 0, o_done=1 next cycle.
- i_start while o_busy=1: ignored, no state change.
- Adder: {cy, sum} = rs1 + (B ^ {W{sub}}) + cin. cin is sub on digit 0 and the registered carry otherwise.
- Equality: eq flag initialised to 1 at start and ANDed with (sum digit == 0) on every digit. On completion, eq = (rs1 == B) when sub=1.
- Less-than: computed on digit N-1 as the MSB of the (XLEN+1)-bit difference of the extended operands. Extension is sign when i_cmp_sig=1, zero otherwise. The result is stored in lt_r on completion.
- o_cmp: updated on the o_done edge with cmp_eq ? eq : lt, then held until the next completion.
- o_rd = OR of the selected terms:
  - [0] sum digit.
  - [1] lt_r in bit 0 of digit 0 only; all other bits and digits are 0. This is the two-pass SLT: the compare operation runs first, then an output pass.
  - [2] bitwise boolean of rs1 and B.
- Mid-operation reset: immediately IDLE, all state at reset values, partial result discarded.

## Timing
- Reset values: o_busy=0, o_done=0, o_cmp=0, cnt=0, carry=0, lt_r=0, eq=1.
- Operation accepted at cycle t: digits occupy cycles t..t+N-1, o_done is high at t+N, and o_cmp is valid from t+N.
- Back-to-back: a new i_start is accepted in the o_done cycle, giving N cycles per operation with no bubble.
- o_rd and o_rd_valid are combinational from the current digit inputs and registered state. There is no output latency.
- o_busy, o_done and o_cmp are registered outputs.

## Test plan
- W=1: add 5+7, imm select, sel=001 -> o_rd serial stream forms 12; o_done at t+32; o_busy high for 31 cycles.
- W=4: sub 3-5 with sig=1, cmp_eq=0 -> o_rd stream forms 0xFFFFFFFE; o_cmp=1. Follow with an output pass using sel=010 -> digit 0 is 0x1, the rest 0.
- W=8: compare 0xFFFFFFFF vs 1 with sig=0 -> o_cmp=0. Same operands with sig=1 -> o_cmp=1. Equal operands 0x1234_5678 with cmp_eq=1 -> o_cmp=1. Operands differing only in the MSB -> o_cmp=0.
- W=2: bool and/or/xor/xnor on 0xF0F0_F0F0 and 0xFF00_FF00 -> results 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0xF00FF00F.
- W=4: i_start pulsed at digit 3 of a running op -> ignored, o_done still at t+8; back-to-back start in the o_done cycle -> accepted.
- Any W: i_rst_n low at digit 5 -> o_busy=0 and o_cmp=0 asynchronously; the next op after release computes correctly with a fresh carry.

Source files
------------

// File: rtl/serv_alu_digit.sv
// serv_alu_digit: digit-serial ALU that processes W bits per cycle, LSB digit first.
// Latency: N = XLEN/W digit cycles. o_rd is combinational. o_done and o_cmp arrive one cycle after the last digit.
// Backpressure: none. i_start is ignored while o_busy is high, and a new start is accepted in the o_done cycle.
//
// Ports:
//   clk, i_rst_n                 clock and asynchronous active-low reset
//   i_start / o_busy / o_done    operation handshake
//   i_op_b_rs2, i_sub, i_bool_op, i_cmp_eq, i_cmp_sig, i_rd_sel
//                                controls; sampled live on the start cycle, latched for later digits
//   i_rs1, i_rs2, i_imm          current operand digits
//   o_rd, o_rd_valid             result digit and its qualifier
//   o_cmp                        compare result of the last completed operation
module serv_alu_digit #(
  parameter int XLEN = 32,
  parameter int W    = 1
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  input  logic         i_op_b_rs2,
  input  logic         i_sub,
  input  logic [1:0]   i_bool_op,
  input  logic         i_cmp_eq,
  input  logic         i_cmp_sig,
  input  logic [2:0]   i_rd_sel,
  input  logic [W-1:0] i_rs1,
  input  logic [W-1:0] i_rs2,
  input  logic [W-1:0] i_imm,
  output logic [W-1:0] o_rd,
  output logic         o_rd_valid,
  output logic         o_cmp
);

  localparam int N  = XLEN / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          carry_r, eq_r, lt_r;

  // Controls captured on the start edge, used for digits 1..N-1
  logic          op_b_rs2_r, sub_r, cmp_eq_r, cmp_sig_r;
  logic [1:0]    bool_op_r;
  logic [2:0]    rd_sel_r;

  logic          start_acc, proc, first, last;
  logic          op_b_rs2, sub, cmp_eq, cmp_sig;
  logic [1:0]    bool_op;
  logic [2:0]    rd_sel;
  logic [W-1:0]  b, bx, sum, bool_res, lt_dig;
  logic [W:0]    add_full;
  logic          cin, cy, eq_now, lt_now, a_ext, b_ext;

  assign o_busy     = (state == RUN);
  assign start_acc  = i_start & ~o_busy;
  assign proc       = start_acc | o_busy;
  assign o_rd_valid = proc;
  assign first      = (cnt == '0);
  assign last       = (cnt == CW'(N - 1));

  // In IDLE the live controls drive digit 0; in RUN the latched copies are used
  assign op_b_rs2 = o_busy ? op_b_rs2_r : i_op_b_rs2;
  assign sub      = o_busy ? sub_r      : i_sub;
  assign bool_op  = o_busy ? bool_op_r  : i_bool_op;
  assign cmp_eq   = o_busy ? cmp_eq_r   : i_cmp_eq;
  assign cmp_sig  = o_busy ? cmp_sig_r  : i_cmp_sig;
  assign rd_sel   = o_busy ? rd_sel_r   : i_rd_sel;

  assign b        = op_b_rs2 ? i_rs2 : i_imm;
  assign bx       = b ^ {W{sub}};
  assign cin      = first ? sub : carry_r;
  assign add_full = {1'b0, i_rs1} + {1'b0, bx} + {{W{1'b0}}, cin};
  assign sum      = add_full[W-1:0];
  assign cy       = add_full[W];

  assign eq_now   = (first ? 1'b1 : eq_r) & (sum == '0);

  // Bit XLEN of ext(rs1) + ext(B)^sub + carry: the extension bits plus the top carry
  assign a_ext    = cmp_sig & i_rs1[W-1];
  assign b_ext    = cmp_sig & b[W-1];
  assign lt_now   = a_ext ^ b_ext ^ sub ^ cy;

  always_comb begin
    bool_res = '0;
    case (bool_op)
      2'b00: bool_res = i_rs1 ^ b;
      2'b01: bool_res = ~(i_rs1 ^ b);
      2'b10: bool_res = i_rs1 | b;
      2'b11: bool_res = i_rs1 & b;
      default: bool_res = '0;
    endcase
  end

  // Stored less-than flag appears only in bit 0 of digit 0 (SLT output pass)
  always_comb begin
    lt_dig    = '0;
    lt_dig[0] = lt_r & first;
  end

  assign o_rd = ({W{rd_sel[0]}} & sum)
              | ({W{rd_sel[1]}} & lt_dig)
              | ({W{rd_sel[2]}} & bool_res);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start_acc && !last) begin
        state_nxt = RUN;
        cnt_nxt   = CW'(1);
      end
      RUN: if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt   = cnt + CW'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      carry_r    <= 1'b0;
      eq_r       <= 1'b1;
      lt_r       <= 1'b0;
      o_done     <= 1'b0;
      o_cmp      <= 1'b0;
      op_b_rs2_r <= 1'b0;
      sub_r      <= 1'b0;
      bool_op_r  <= 2'b00;
      cmp_eq_r   <= 1'b0;
      cmp_sig_r  <= 1'b0;
      rd_sel_r   <= 3'b000;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_done <= proc & last;
      if (start_acc) begin
        op_b_rs2_r <= i_op_b_rs2;
        sub_r      <= i_sub;
        bool_op_r  <= i_bool_op;
        cmp_eq_r   <= i_cmp_eq;
        cmp_sig_r  <= i_cmp_sig;
        rd_sel_r   <= i_rd_sel;
      end
      if (proc) begin
        carry_r <= cy;
        eq_r    <= eq_now;
        if (last) begin
          lt_r  <= lt_now;
          o_cmp <= cmp_eq ? eq_now : lt_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_serv_alu_digit.sv
// tb_serv_alu_digit: scoreboard bench for serv_alu_digit with W=4 (8 digits per operation).
// Latency: expected digits are queued at drive time and compared half a cycle later; o_done/o_cmp are checked the cycle after the last digit.
// Backpressure: none. The bench drives back-to-back operations and idle gaps.
module tb_serv_alu_digit;

  localparam int XLEN = 32;
  localparam int W    = 4;
  localparam int N    = XLEN / W;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         o_busy, o_done, o_rd_valid, o_cmp;
  logic         i_op_b_rs2 = 1'b0, i_sub = 1'b0, i_cmp_eq = 1'b0, i_cmp_sig = 1'b0;
  logic [1:0]   i_bool_op = 2'b00;
  logic [2:0]   i_rd_sel = 3'b000;
  logic [W-1:0] i_rs1 = '0, i_rs2 = '0, i_imm = '0;
  logic [W-1:0] o_rd;

  serv_alu_digit #(.XLEN(XLEN), .W(W)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .i_op_b_rs2 (i_op_b_rs2),
    .i_sub      (i_sub),
    .i_bool_op  (i_bool_op),
    .i_cmp_eq   (i_cmp_eq),
    .i_cmp_sig  (i_cmp_sig),
    .i_rd_sel   (i_rd_sel),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_imm      (i_imm),
    .o_rd       (o_rd),
    .o_rd_valid (o_rd_valid),
    .o_cmp      (o_cmp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic         cmp_q[$];
  logic         pending = 1'b0;
  logic         lt_mod  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Random values on the controls a running operation must ignore
  task automatic scramble_ctrl();
    i_op_b_rs2 = 1'($urandom);
    i_sub      = 1'($urandom);
    i_bool_op  = 2'($urandom);
    i_cmp_eq   = 1'($urandom);
    i_cmp_sig  = 1'($urandom);
    i_rd_sel   = 3'($urandom);
  endtask

  task automatic check_done_slot();
    chk("done", {31'd0, o_done}, {31'd0, pending});
    if (pending) chk("cmp", {31'd0, o_cmp}, {31'd0, cmp_q.pop_front()});
    pending = 1'b0;
  endtask

  // Runs one full operation starting at posedge+1; returns at posedge+1 after the last digit.
  // ghost > 0 pulses i_start again at that digit, which must be ignored.
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic use_rs2,
                          input logic sub, input logic [1:0] bop, input logic ceq,
                          input logic sig, input logic [2:0] sel, input int ghost);
    logic [31:0] bm, sum, bres, res;
    logic [32:0] ae, be, dif;
    logic        eq, lt;
    bm   = sub ? ~b : b;
    sum  = a + bm + {31'd0, sub};
    case (bop)
      2'b00:   bres = a ^ b;
      2'b01:   bres = ~(a ^ b);
      2'b10:   bres = a | b;
      default: bres = a & b;
    endcase
    res  = (sel[0] ? sum : 32'd0) | (sel[1] ? {31'd0, lt_mod} : 32'd0) | (sel[2] ? bres : 32'd0);
    ae   = {sig & a[31], a};
    be   = {sig & b[31], b};
    if (sub) be = ~be;
    dif  = ae + be + {32'd0, sub};
    lt   = dif[32];
    eq   = (sum == 32'd0);
    for (int d = 0; d < N; d++) begin
      i_start = (d == 0) || (d == ghost);
      if (d == 0) begin
        i_op_b_rs2 = use_rs2; i_sub = sub; i_bool_op = bop;
        i_cmp_eq = ceq; i_cmp_sig = sig; i_rd_sel = sel;
      end else begin
        scramble_ctrl();
      end
      i_rs1 = a[d*W +: W];
      i_rs2 = use_rs2 ? b[d*W +: W] : W'($urandom);
      i_imm = use_rs2 ? W'($urandom) : b[d*W +: W];
      exp_q.push_back(res[d*W +: W]);
      @(negedge clk);
      if (d == 0) check_done_slot();
      chk("busy", {31'd0, o_busy}, {31'd0, (d > 0)});
      chk("rd_valid", {31'd0, o_rd_valid}, 32'd1);
      chk($sformatf("rd_d%0d", d), {28'd0, o_rd}, {28'd0, exp_q.pop_front()});
      @(posedge clk); #1;
    end
    lt_mod  = lt;
    pending = 1'b1;
    cmp_q.push_back(ceq ? eq : lt);
  endtask

  task automatic idle();
    i_start = 1'b0;
    scramble_ctrl();
    @(negedge clk);
    check_done_slot();
    chk("busy_idle", {31'd0, o_busy}, 32'd0);
    chk("rd_valid_idle", {31'd0, o_rd_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_cmp",  {31'd0, o_cmp},  32'd0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    idle();

    // Add with immediate operand
    drive_op(32'd5, 32'd7, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 0);
    idle();
    // Signed 3-5, then back-to-back SLT output pass
    drive_op(32'd3, 32'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 0);
    drive_op(32'd0, 32'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'b010, 0);
    idle();
    // Unsigned vs signed compare, equality
    drive_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 0);
    drive_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 0);
    drive_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 0);
    drive_op(32'h1234_5678, 32'h9234_5678, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 0);
    idle();
    // Boolean ops
    for (int k = 0; k < 4; k++) begin
      logic [1:0] bop;
      bop = (k == 0) ? 2'b11 : (k == 1) ? 2'b10 : (k == 2) ? 2'b00 : 2'b01;
      drive_op(32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0, bop, 1'b0, 1'b0, 3'b100, 0);
    end
    idle();
    // Ghost start at digit 3, then a back-to-back start in the done cycle
    drive_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 3);
    drive_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 0);
    idle();
    // A few random mixed operations
    for (int k = 0; k < 6; k++) begin
      logic [2:0] sel;
      sel = 3'b001 << $urandom_range(0, 2);
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), sel, 0);
    end
    idle();

    // Leave o_cmp=1 and lt=1, then reset in the middle of an operation
    drive_op(32'd3, 32'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 0);
    idle();
    for (int d = 0; d < 6; d++) begin
      i_start = (d == 0);
      i_op_b_rs2 = 1'b1; i_sub = 1'b0; i_rd_sel = 3'b001;
      i_rs1 = 4'hF; i_rs2 = 4'hF;
      if (d < 5) begin
        @(posedge clk); #1;
      end
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_cmp",  {31'd0, o_cmp},  32'd0);
    chk("arst_done", {31'd0, o_done}, 32'd0);
    i_start = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    lt_mod  = 1'b0;
    pending = 1'b0;
    @(posedge clk); #1;
    // Stored lt must read back as cleared; sum must start from a fresh carry
    drive_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'b011, 0);
    drive_op(32'h0000_0009, 32'h0000_0006, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3'b001, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
